mode_sequencer: RTL and testbench

- Clocked, parametrised successor to the combinational mode selector used by the display/LED controller.
- Steps a mode register through NUM_MODES values on each debounced press of the check button, wrapping to 0 after the last mode.
- A flick request reverts to earlier modes through a bounded history stack; a direct load path lets firmware jump to any mode.
- Sits between the raw button pads and the mode-dependent pattern generators.

---
 rtl/mode_pkg.sv | 23 ++
 rtl/sync_debounce.sv | 51 +++++
 rtl/mode_sequencer.sv | 135 +++++++++++++
 tb/tb_mode_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mode_pkg.sv
// Shared constants and enumerations for the mode sequencer and its users.
package mode_pkg;

  localparam int unsigned NumModesDef = 6;
  localparam int unsigned ModeWDef    = 3;

  typedef enum logic [ModeWDef-1:0] {
    MODE_0,
    MODE_1,
    MODE_2,
    MODE_3,
    MODE_4,
    MODE_5
  } mode_e;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_ADV,
    ACT_REV,
    ACT_LOAD
  } act_e;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser with optional debounce counter and a rising-edge pulse output.
module sync_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          BYPASS          = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o
);

  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic            prev_q;
  logic            out_level;
  logic [CntW-1:0] cnt_q, cnt_d;

  // The sample that completes the stable run flips the level directly.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign out_level = BYPASS ? sync_q[1] : level_q;
  assign rise_o    = out_level & ~prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      prev_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], async_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      prev_q  <= out_level;
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// Mode register stepped by debounced presses, reverted through a bounded history stack,
// and directly loadable by firmware.
module mode_sequencer
  import mode_pkg::*;
#(
  parameter int unsigned NUM_MODES       = NumModesDef,
  parameter int unsigned MODE_W          = ModeWDef,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HIST_DEPTH      = 4,
  parameter int unsigned HIST_W          = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              check,
  input  logic              flick,
  input  logic              load_en,
  input  logic [MODE_W-1:0] load_mode,
  output logic [MODE_W-1:0] mode,
  output logic              mode_changed,
  output logic [HIST_W-1:0] hist_count,
  output logic              hist_empty,
  output logic              load_err
);

  localparam int unsigned       PtrW        = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam logic [MODE_W-1:0] LastMode    = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W:0]   NumModesExt = (MODE_W + 1)'(NUM_MODES);
  localparam logic [HIST_W-1:0] HistFull    = HIST_W'(HIST_DEPTH);
  localparam logic [PtrW-1:0]   PtrLast     = PtrW'(HIST_DEPTH - 1);

  logic              adv, rev;
  act_e              act;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              mode_changed_q;
  logic              load_err_q, load_err_d;
  logic [HIST_W-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0]   top_q, top_d, top_inc, top_dec;
  logic              push;
  logic [MODE_W-1:0] stack_q [HIST_DEPTH];

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BYPASS         (1'b0)
  ) u_check (
    .clk_i  (clk),
    .rst_ni (rst),
    .async_i(check),
    .rise_o (adv)
  );

  sync_debounce #(
    .DEBOUNCE_CYCLES(1),
    .BYPASS         (1'b1)
  ) u_flick (
    .clk_i  (clk),
    .rst_ni (rst),
    .async_i(flick),
    .rise_o (rev)
  );

  // Lower-priority events in the same cycle are dropped, even when a load is rejected.
  always_comb begin
    if (load_en)  act = ACT_LOAD;
    else if (rev) act = ACT_REV;
    else if (adv) act = ACT_ADV;
    else          act = ACT_NONE;
  end

  assign top_inc = (top_q == PtrLast) ? '0 : top_q + 1'b1;
  assign top_dec = (top_q == '0) ? PtrLast : top_q - 1'b1;

  always_comb begin
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    top_d      = top_q;
    push       = 1'b0;
    load_err_d = 1'b0;
    unique case (act)
      ACT_ADV: begin
        push   = 1'b1;
        mode_d = (mode_q == LastMode) ? '0 : mode_q + 1'b1;
      end
      ACT_REV: begin
        if (cnt_q != '0) begin
          mode_d = stack_q[top_q];
          top_d  = top_dec;
          cnt_d  = cnt_q - 1'b1;
        end else begin
          mode_d = '0;
        end
      end
      ACT_LOAD: begin
        if ({1'b0, load_mode} < NumModesExt) begin
          push   = 1'b1;
          mode_d = load_mode;
        end else begin
          load_err_d = 1'b1;
        end
      end
      default: ;
    endcase
    // A full stack keeps its count; the new top lands on the oldest slot.
    if (push) begin
      top_d = top_inc;
      if (cnt_q != HistFull) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q         <= MODE_W'(MODE_0);
      mode_changed_q <= 1'b0;
      load_err_q     <= 1'b0;
      cnt_q          <= '0;
      top_q          <= '0;
    end else begin
      mode_q         <= mode_d;
      mode_changed_q <= (mode_d != mode_q);
      load_err_q     <= load_err_d;
      cnt_q          <= cnt_d;
      top_q          <= top_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stack_q[top_inc] <= mode_q;
  end

  assign mode         = mode_q;
  assign mode_changed = mode_changed_q;
  assign load_err     = load_err_q;
  assign hist_count   = cnt_q;
  assign hist_empty   = (cnt_q == '0);

endmodule

// File: tb/tb_mode_sequencer.sv
// Self-checking bench for mode_sequencer: vector table, timing corner cases, random ops vs model.
module tb_mode_sequencer;

  localparam int unsigned NM = 6;
  localparam int unsigned MW = 3;
  localparam int unsigned DB = 4;
  localparam int unsigned HD = 4;
  localparam int unsigned HW = 3;

  typedef enum int {OpPress, OpFlick, OpLoad} op_e;
  typedef struct {
    op_e op;
    int  arg;
    int  exp_mode;
    int  exp_cnt;
    int  exp_mc;
    int  exp_le;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          check = 1'b0;
  logic          flick = 1'b0;
  logic          load_en = 1'b0;
  logic [MW-1:0] load_mode = '0;
  logic [MW-1:0] mode;
  logic          mode_changed;
  logic [HW-1:0] hist_count;
  logic          hist_empty;
  logic          load_err;

  int n_cmp = 0;
  int n_err = 0;
  int mc_seen = 0;
  int le_seen = 0;
  int mc0, le0;

  int exp_mode;
  int hist[$];

  always #5 clk = ~clk;

  mode_sequencer #(
    .NUM_MODES      (NM),
    .MODE_W         (MW),
    .DEBOUNCE_CYCLES(DB),
    .HIST_DEPTH     (HD),
    .HIST_W         (HW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .check       (check),
    .flick       (flick),
    .load_en     (load_en),
    .load_mode   (load_mode),
    .mode        (mode),
    .mode_changed(mode_changed),
    .hist_count  (hist_count),
    .hist_empty  (hist_empty),
    .load_err    (load_err)
  );

  always @(negedge clk) begin
    if (mode_changed === 1'b1) mc_seen++;
    if (load_err === 1'b1) le_seen++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic snap();
    mc0 = mc_seen;
    le0 = le_seen;
  endtask

  task automatic chk_state(input string name, input int em, input int ec, input int emc,
                           input int ele);
    chk({name, ".mode"}, 32'(mode), em);
    chk({name, ".count"}, 32'(hist_count), ec);
    chk({name, ".empty"}, 32'(hist_empty), (ec == 0) ? 1 : 0);
    chk({name, ".mc_pulses"}, mc_seen - mc0, emc);
    chk({name, ".err_pulses"}, le_seen - le0, ele);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    check = 1'b0;
    flick = 1'b0;
    load_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic press(input int hold);
    check = 1'b1;
    repeat (hold) @(negedge clk);
    check = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic flick_pulse();
    flick = 1'b1;
    repeat (3) @(negedge clk);
    flick = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_load(input int v);
    load_en = 1'b1;
    load_mode = MW'(v);
    @(negedge clk);
    load_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_op(input op_e op, input int arg);
    case (op)
      OpPress: press(6);
      OpFlick: flick_pulse();
      default: do_load(arg);
    endcase
  endtask

  // Reference model: event-level rules on a plain queue used as a bounded LIFO.
  task automatic model_op(input op_e op, input int arg, output int emc, output int ele);
    int old = exp_mode;
    ele = 0;
    case (op)
      OpPress: begin
        hist.push_back(exp_mode);
        if (hist.size() > HD) void'(hist.pop_front());
        exp_mode = (exp_mode + 1) % NM;
      end
      OpFlick: exp_mode = (hist.size() > 0) ? hist.pop_back() : 0;
      default: begin
        if (arg < NM) begin
          hist.push_back(exp_mode);
          if (hist.size() > HD) void'(hist.pop_front());
          exp_mode = arg;
        end else begin
          ele = 1;
        end
      end
    endcase
    emc = (exp_mode != old) ? 1 : 0;
  endtask

  initial begin
    vec_t vecs[$];
    int emc, ele;

    vecs.push_back('{OpPress, 0, 1, 1, 1, 0});
    vecs.push_back('{OpPress, 0, 2, 2, 1, 0});
    vecs.push_back('{OpPress, 0, 3, 3, 1, 0});
    vecs.push_back('{OpPress, 0, 4, 4, 1, 0});
    vecs.push_back('{OpPress, 0, 5, 4, 1, 0});
    vecs.push_back('{OpPress, 0, 0, 4, 1, 0});
    vecs.push_back('{OpFlick, 0, 5, 3, 1, 0});
    vecs.push_back('{OpFlick, 0, 4, 2, 1, 0});
    vecs.push_back('{OpFlick, 0, 3, 1, 1, 0});
    vecs.push_back('{OpFlick, 0, 2, 0, 1, 0});
    vecs.push_back('{OpFlick, 0, 0, 0, 1, 0});
    vecs.push_back('{OpFlick, 0, 0, 0, 0, 0});
    vecs.push_back('{OpPress, 0, 1, 1, 1, 0});
    vecs.push_back('{OpPress, 0, 2, 2, 1, 0});
    vecs.push_back('{OpPress, 0, 3, 3, 1, 0});
    vecs.push_back('{OpFlick, 0, 2, 2, 1, 0});
    vecs.push_back('{OpFlick, 0, 1, 1, 1, 0});
    vecs.push_back('{OpFlick, 0, 0, 0, 1, 0});
    vecs.push_back('{OpFlick, 0, 0, 0, 0, 0});
    vecs.push_back('{OpLoad,  6, 0, 0, 0, 1});
    vecs.push_back('{OpLoad,  4, 4, 1, 1, 0});
    vecs.push_back('{OpLoad,  4, 4, 2, 0, 0});
    vecs.push_back('{OpLoad,  7, 4, 2, 0, 1});

    // Reset values while held in reset.
    #12;
    snap();
    chk_state("reset", 0, 0, 0, 0);
    chk("reset.mode_changed", 32'(mode_changed), 0);
    chk("reset.load_err", 32'(load_err), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      snap();
      do_op(vecs[i].op, vecs[i].arg);
      chk_state($sformatf("vec%0d", i), vecs[i].exp_mode, vecs[i].exp_cnt, vecs[i].exp_mc,
                vecs[i].exp_le);
    end

    // Three-cycle glitch is filtered.
    do_reset();
    snap();
    press(3);
    chk_state("glitch", 0, 0, 0, 0);

    // Four-cycle press: mode moves on the 7th edge after the raw rise.
    snap();
    check = 1'b1;
    repeat (4) @(negedge clk);
    check = 1'b0;
    repeat (2) @(negedge clk);
    chk("lat.edge6_mode", 32'(mode), 0);
    @(negedge clk);
    chk("lat.edge7_mode", 32'(mode), 1);
    chk("lat.edge7_pulse", 32'(mode_changed), 1);
    repeat (12) @(negedge clk);
    chk_state("lat.after", 1, 1, 1, 0);

    // Advance, revert and load(2) land on the same edge: load wins, one push.
    snap();
    check = 1'b1;
    repeat (4) @(negedge clk);
    flick = 1'b1;
    repeat (2) @(negedge clk);
    load_en = 1'b1;
    load_mode = 3'd2;
    @(negedge clk);
    load_en = 1'b0;
    chk("tri.mode_at_edge", 32'(mode), 2);
    @(negedge clk);
    check = 1'b0;
    flick = 1'b0;
    repeat (12) @(negedge clk);
    chk_state("tri", 2, 2, 1, 0);

    // Revert and advance on the same edge: pop only.
    snap();
    check = 1'b1;
    repeat (4) @(negedge clk);
    flick = 1'b1;
    repeat (4) @(negedge clk);
    check = 1'b0;
    flick = 1'b0;
    repeat (12) @(negedge clk);
    chk_state("rev_adv", 1, 1, 1, 0);

    // Reset mid-debounce clears everything at once and leaves no pending event.
    check = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    snap();
    chk_state("midrst", 0, 0, 0, 0);
    chk("midrst.mode_changed", 32'(mode_changed), 0);
    check = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    chk_state("midrst.after", 0, 0, 0, 0);

    // Random operation stream against the queue model.
    do_reset();
    exp_mode = 0;
    hist.delete();
    for (int i = 0; i < 40; i++) begin
      op_e op;
      int  arg;
      op  = op_e'($urandom_range(0, 2));
      arg = int'($urandom_range(0, 7));
      snap();
      do_op(op, arg);
      model_op(op, arg, emc, ele);
      chk_state($sformatf("rnd%0d", i), exp_mode, hist.size(), emc, ele);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
